// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver types, parameter limits and frame length helper
package uart_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} rx_state_t;
  localparam int MIN_DATA_BITS = 5;
  localparam int MAX_DATA_BITS = 9;
  localparam int MIN_STOP_BITS = 1;
  localparam int MAX_STOP_BITS = 2;
  function automatic int frame_len(int data_bits, int parity_en, int stop_bits);
    return data_bits + parity_en + stop_bits;
  endfunction
endpackage

// File: rtl/uart_bit_counter.sv
// uart_bit_counter: frame bit counter with clear, enable and terminal-count flag
module uart_bit_counter #(
  parameter int LEN = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(LEN + 1);
  logic [W-1:0] cnt;
  assign tc = en && !clr && cnt == W'(LEN - 1);
  // count accepted bits; clear wins over enable
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/uart_rx_frame_sr.sv
// uart_rx_frame_sr: deserialises one UART frame and flags parity, framing and overrun errors
module uart_rx_frame_sr
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int LSB_FIRST  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 shift_strobe,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_full,
  output logic                 frame_done,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun_error
);
  localparam int FL = frame_len(DATA_BITS, PARITY_EN, STOP_BITS);
  if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data
    $error("DATA_BITS out of range");
  end
  if (STOP_BITS < MIN_STOP_BITS || STOP_BITS > MAX_STOP_BITS) begin : g_bad_stop
    $error("STOP_BITS out of range");
  end
  if (PARITY_EN < 0 || PARITY_EN > 1) begin : g_bad_par
    $error("PARITY_EN must be 0 or 1");
  end
  rx_state_t state;
  logic [FL-1:0] sr;
  logic [DATA_BITS-1:0] field, rev, data_w;
  logic tc, perr_w, ferr_w;
  uart_bit_counter #(.LEN(FL)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(frame_start && state != DONE),
    .en(shift_strobe && state == SHIFT),
    .tc(tc)
  );
  // sr[i] holds the i-th received bit; the data field is reversed for MSB-first frames
  always_comb begin
    field = sr[DATA_BITS-1:0];
    rev = '0;
    for (int i = 0; i < DATA_BITS; i++) rev[i] = field[DATA_BITS-1-i];
    data_w = LSB_FIRST != 0 ? field : rev;
    perr_w = PARITY_EN != 0 && (^field ^ sr[DATA_BITS] ^ (PARITY_ODD != 0));
    ferr_w = ~&sr[FL-1:FL-STOP_BITS];
  end
  // frame FSM, shift register and registered host-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      rx_data <= '0;
      rx_full <= 1'b0;
      frame_done <= 1'b0;
      parity_error <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (frame_start) begin
          state <= SHIFT;
          sr <= '0;
        end
        SHIFT: if (frame_start) sr <= '0;
          else if (shift_strobe) begin
            sr <= {serial_in, sr[FL-1:1]};
            if (tc) state <= DONE;
          end
        DONE: begin
          state <= IDLE;
          rx_data <= data_w;
          parity_error <= perr_w;
          framing_error <= ferr_w;
          frame_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (state == DONE) begin
        rx_full <= 1'b1;
        overrun_error <= rx_full && !data_read;
      end else if (data_read) begin
        rx_full <= 1'b0;
        overrun_error <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_frame_sr.sv
// tb_uart_rx_frame_sr: directed checks of 8N1, 8E1 and 7O2 MSB-first receivers
module tb_uart_rx_frame_sr;
  logic clk = 1'b0;
  logic rst, si;
  logic [2:0] fs, ss, dr, done, full, pe, fe, oe;
  logic [7:0] rd0, rd1;
  logic [6:0] rd2;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  uart_rx_frame_sr #(.DATA_BITS(8)) u0 (
    .clk(clk), .rst(rst), .frame_start(fs[0]), .shift_strobe(ss[0]), .serial_in(si),
    .data_read(dr[0]), .rx_data(rd0), .rx_full(full[0]), .frame_done(done[0]),
    .parity_error(pe[0]), .framing_error(fe[0]), .overrun_error(oe[0])
  );
  uart_rx_frame_sr #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .rst(rst), .frame_start(fs[1]), .shift_strobe(ss[1]), .serial_in(si),
    .data_read(dr[1]), .rx_data(rd1), .rx_full(full[1]), .frame_done(done[1]),
    .parity_error(pe[1]), .framing_error(fe[1]), .overrun_error(oe[1])
  );
  uart_rx_frame_sr #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2), .LSB_FIRST(0)) u2 (
    .clk(clk), .rst(rst), .frame_start(fs[2]), .shift_strobe(ss[2]), .serial_in(si),
    .data_read(dr[2]), .rx_data(rd2), .rx_full(full[2]), .frame_done(done[2]),
    .parity_error(pe[2]), .framing_error(fe[2]), .overrun_error(oe[2])
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // b[i] is the i-th bit on the line; returns at the negedge of the DONE cycle
  task automatic send(input int d, input logic [15:0] b, input int n);
    @(negedge clk);
    fs[d] = 1'b1;
    @(negedge clk);
    fs[d] = 1'b0;
    for (int i = 0; i < n; i++) begin
      ss[d] = 1'b1;
      si = b[i];
      @(negedge clk);
    end
    ss[d] = 1'b0;
  endtask
  task automatic partial(input int d, input int n);
    @(negedge clk);
    fs[d] = 1'b1;
    @(negedge clk);
    fs[d] = 1'b0;
    for (int i = 0; i < n; i++) begin
      ss[d] = 1'b1;
      si = i[0];
      @(negedge clk);
    end
    ss[d] = 1'b0;
  endtask
  task automatic read(input int d);
    dr[d] = 1'b1;
    @(negedge clk);
    dr[d] = 1'b0;
  endtask
  initial begin
    rst = 1'b1; fs = '0; ss = '0; dr = '0; si = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_data0", rd0, 0);
    chk("rst_data2", rd2, 0);
    chk("rst_full", full, 0);
    chk("rst_flags", {pe, fe, oe, done}, 0);
    send(0, 16'h1A5, 9);
    chk("8n1_done_early", done[0], 0);
    @(negedge clk);
    chk("8n1_done", done[0], 1);
    chk("8n1_data", rd0, 'hA5);
    chk("8n1_err", {pe[0], fe[0], oe[0]}, 0);
    chk("8n1_full", full[0], 1);
    @(negedge clk);
    chk("8n1_pulse", done[0], 0);
    read(0);
    chk("8n1_read", full[0], 0);
    send(1, 16'h3A5, 10);
    @(negedge clk);
    chk("8e1_data", rd1, 'hA5);
    chk("8e1_perr1", pe[1], 1);
    read(1);
    chk("8e1_perr_hold", pe[1], 1);
    send(1, 16'h2A5, 10);
    @(negedge clk);
    chk("8e1_perr0", pe[1], 0);
    chk("8e1_ovr", oe[1], 0);
    read(1);
    send(2, 16'h1C1, 10);
    @(negedge clk);
    chk("7o2_data", rd2, 'h41);
    chk("7o2_ferr", fe[2], 1);
    chk("7o2_perr", pe[2], 0);
    read(2);
    send(2, 16'h368, 10);
    @(negedge clk);
    chk("7o2_order", rd2, 'h0B);
    chk("7o2_clean", {pe[2], fe[2]}, 0);
    read(2);
    send(0, 16'h111, 9);
    @(negedge clk);
    chk("ovr_first", oe[0], 0);
    send(0, 16'h122, 9);
    @(negedge clk);
    chk("ovr_data", rd0, 'h22);
    chk("ovr_set", oe[0], 1);
    chk("ovr_full", full[0], 1);
    read(0);
    chk("ovr_clr", {full[0], oe[0]}, 0);
    partial(0, 4);
    send(0, 16'h13C, 9);
    @(negedge clk);
    chk("abort_data", rd0, 'h3C);
    chk("abort_err", {pe[0], fe[0], oe[0]}, 0);
    partial(0, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_data", rd0, 0);
    chk("rst_mid_flags", {full[0], done[0], pe[0], fe[0], oe[0]}, 0);
    for (int i = 0; i < 9; i++) begin
      ss[0] = 1'b1;
      si = 1'b1;
      @(negedge clk);
    end
    ss[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_ignore", {full[0], rd0}, 0);
    send(0, 16'h155, 9);
    @(negedge clk);
    chk("rd_same_pre", {full[0], rd0}, 'h155);
    send(0, 16'h166, 9);
    dr[0] = 1'b1;
    @(negedge clk);
    dr[0] = 1'b0;
    chk("rd_same_ovr", oe[0], 0);
    chk("rd_same_full", full[0], 1);
    chk("rd_same_data", rd0, 'h66);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
